robot_cmd_sequencer: RTL and testbench

Command controller between the `uart_rx` byte stream and IR command decode on one side, and the robot motion outputs on the other. It frames and checks UART command packets and arbitrates them against IR remote commands. It then executes each accepted motion command for a timed duration, honouring emergency stop. It replaces the raw byte-to-LED latch at top level as the single owner of `rx_ready`.

---
 rtl/robot_pkg.sv | 33 +++
 rtl/cmd_frame_parser.sv | 84 ++++++++
 rtl/robot_cmd_sequencer.sv | 149 ++++++++++++++
 tb/tb_robot_cmd_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/robot_pkg.sv
// Shared types and constants for the robot command path: motion codes,
// frame header, duration unit and the parser/executor state encodings.
package robot_pkg;

    typedef enum logic [2:0] {
        M_STOP  = 3'd0,
        M_FWD   = 3'd1,
        M_REV   = 3'd2,
        M_LEFT  = 3'd3,
        M_RIGHT = 3'd4
    } motion_e;

    typedef enum logic [2:0] {
        P_HDR,
        P_CMD,
        P_SPD,
        P_DUR,
        P_CHK
    } parse_state_e;

    typedef enum logic {
        E_IDLE,
        E_RUN
    } exec_state_e;

    localparam logic [7:0] FRAME_HDR   = 8'hA5;
    localparam int         DUR_UNIT_MS = 10;

    function automatic logic is_motion(input logic [7:0] code);
        return code <= 8'(M_RIGHT);
    endfunction

endpackage

// File: rtl/cmd_frame_parser.sv
// UART frame parser: A5,CMD,SPD,DUR,CHK with checksum, CMD range and inter-byte timeout.
// frm_vld is combinational on the CHK byte, frame_err one cycle later; stalls rx while the slot is full.
module cmd_frame_parser
    import robot_pkg::*;
#(
    parameter int CLKS_PER_MS = 50_000,
    parameter int TIMEOUT_MS  = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    output logic       rx_ready,
    input  logic       slot_full,
    output logic       frm_vld,
    output logic [7:0] frm_cmd,
    output logic [7:0] frm_spd,
    output logic [7:0] frm_dur,
    output logic       frame_err,
    output logic [7:0] err_count
);

    localparam int TIMEOUT_CYC = CLKS_PER_MS * TIMEOUT_MS;
    localparam int GAP_W       = $clog2(TIMEOUT_CYC + 1);

    parse_state_e     state, state_nxt;
    logic [7:0]       cmd_q, spd_q, dur_q;
    logic [GAP_W-1:0] gap_cnt;
    logic             consume, chk_good, timeout_hit, bad_frame;

    assign rx_ready    = ~slot_full;
    assign consume     = rx_valid & rx_ready;
    assign chk_good    = (rx_byte == (cmd_q ^ spd_q ^ dur_q)) && is_motion(cmd_q);
    assign timeout_hit = (state != P_HDR) && !consume && (gap_cnt == GAP_W'(TIMEOUT_CYC));
    assign bad_frame   = (consume && (state == P_CHK) && !chk_good) || timeout_hit;
    assign frm_vld     = consume && (state == P_CHK) && chk_good;
    assign frm_cmd     = cmd_q;
    assign frm_spd     = spd_q;
    assign frm_dur     = dur_q;

    always_comb begin
        state_nxt = state;
        if (timeout_hit) begin
            state_nxt = P_HDR;
        end else if (consume) begin
            case (state)
                P_HDR:   state_nxt = (rx_byte == FRAME_HDR) ? P_CMD : P_HDR;
                P_CMD:   state_nxt = P_SPD;
                P_SPD:   state_nxt = P_DUR;
                P_DUR:   state_nxt = P_CHK;
                default: state_nxt = P_HDR;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= P_HDR;
            cmd_q     <= '0;
            spd_q     <= '0;
            dur_q     <= '0;
            gap_cnt   <= '0;
            frame_err <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_nxt;
            frame_err <= bad_frame;
            // Gap timer only runs while a frame is open and restarts on every byte.
            gap_cnt   <= (consume || state_nxt == P_HDR) ? '0 : gap_cnt + GAP_W'(1);
            if (consume) begin
                case (state)
                    P_CMD:   cmd_q <= rx_byte;
                    P_SPD:   spd_q <= rx_byte;
                    P_DUR:   dur_q <= rx_byte;
                    default: ;
                endcase
            end
            if (bad_frame && err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: rtl/robot_cmd_sequencer.sv
// Pending slot, IR/UART arbitration and timed motion executor; IR starts in 1 cycle, a frame in 2 after CHK.
// rx is held off while one good frame waits in the slot; estop overrides everything and flushes the slot.
module robot_cmd_sequencer
    import robot_pkg::*;
#(
    parameter int         CLKS_PER_MS = 50_000,
    parameter int         TIMEOUT_MS  = 20,
    parameter logic [7:0] IR_SPEED    = 8'd128,
    parameter int         IR_DUR_MS   = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    output logic       rx_ready,
    input  logic [2:0] ir_cmd,
    input  logic       ir_valid,
    input  logic       estop,
    output logic [2:0] motor_cmd,
    output logic [7:0] motor_speed,
    output logic       busy,
    output logic       frame_err,
    output logic [7:0] err_count,
    output logic [7:0] last_cmd
);

    localparam int PRE_W = $clog2(CLKS_PER_MS + 1);

    exec_state_e      state, state_nxt;
    logic [2:0]       cmd_nxt, new_cmd, slot_cmd;
    logic [7:0]       spd_nxt, new_spd, slot_spd, slot_dur;
    logic [15:0]      ms_left, ms_nxt, new_ms;
    logic             untimed, untimed_nxt, new_untimed;
    logic [PRE_W-1:0] presc, presc_nxt;
    logic             slot_full, frm_vld;
    logic [7:0]       frm_cmd, frm_spd, frm_dur;
    logic             tick, ir_ok, can_preempt, take_ir, take_slot;

    cmd_frame_parser #(
        .CLKS_PER_MS (CLKS_PER_MS),
        .TIMEOUT_MS  (TIMEOUT_MS)
    ) u_parser (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .slot_full (slot_full),
        .frm_vld   (frm_vld),
        .frm_cmd   (frm_cmd),
        .frm_spd   (frm_spd),
        .frm_dur   (frm_dur),
        .frame_err (frame_err),
        .err_count (err_count)
    );

    assign busy = (state == E_RUN);

    always_comb begin
        tick        = (presc == PRE_W'(CLKS_PER_MS - 1));
        ir_ok       = ir_valid && !estop && is_motion({5'd0, ir_cmd});
        // A timed run can only be interrupted by STOP; untimed runs accept anything.
        can_preempt = (state == E_IDLE) || untimed;
        take_ir     = ir_ok && (can_preempt || ir_cmd == M_STOP);
        take_slot   = !take_ir && slot_full && !estop && (can_preempt || slot_cmd == M_STOP);

        new_cmd     = take_ir ? ir_cmd : slot_cmd;
        new_spd     = take_ir ? IR_SPEED : slot_spd;
        new_ms      = take_ir ? 16'(IR_DUR_MS) : 16'(slot_dur) * 16'(DUR_UNIT_MS);
        new_untimed = !take_ir && (slot_dur == 8'd0);

        state_nxt   = state;
        cmd_nxt     = motor_cmd;
        spd_nxt     = motor_speed;
        ms_nxt      = ms_left;
        untimed_nxt = untimed;
        presc_nxt   = (state == E_RUN && !tick) ? presc + PRE_W'(1) : '0;

        if (estop) begin
            state_nxt = E_IDLE;
            cmd_nxt   = M_STOP;
            spd_nxt   = 8'd0;
        end else if (take_ir || take_slot) begin
            presc_nxt = '0;
            if (new_cmd == M_STOP) begin
                state_nxt = E_IDLE;
                cmd_nxt   = M_STOP;
                spd_nxt   = 8'd0;
            end else begin
                state_nxt   = E_RUN;
                cmd_nxt     = new_cmd;
                spd_nxt     = new_spd;
                ms_nxt      = new_ms;
                untimed_nxt = new_untimed;
            end
        end else if (state == E_RUN && !untimed && tick) begin
            if (ms_left <= 16'd1) begin
                state_nxt = E_IDLE;
                cmd_nxt   = M_STOP;
                spd_nxt   = 8'd0;
            end else begin
                ms_nxt = ms_left - 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= E_IDLE;
            motor_cmd   <= M_STOP;
            motor_speed <= '0;
            ms_left     <= '0;
            untimed     <= 1'b0;
            presc       <= '0;
        end else begin
            state       <= state_nxt;
            motor_cmd   <= cmd_nxt;
            motor_speed <= spd_nxt;
            ms_left     <= ms_nxt;
            untimed     <= untimed_nxt;
            presc       <= presc_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_full <= 1'b0;
            slot_cmd  <= '0;
            slot_spd  <= '0;
            slot_dur  <= '0;
            last_cmd  <= '0;
        end else begin
            if (frm_vld) begin
                last_cmd <= frm_cmd;
            end
            if (estop) begin
                slot_full <= 1'b0;
            end else if (frm_vld) begin
                slot_full <= 1'b1;
                slot_cmd  <= frm_cmd[2:0];
                slot_spd  <= frm_spd;
                slot_dur  <= frm_dur;
            end else if (take_slot) begin
                slot_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_robot_cmd_sequencer.sv
// Directed walk through the command sequencer's frame, IR, timeout and estop behaviour,
// followed by random frames predicted from the frame rules.
module tb_robot_cmd_sequencer;

    localparam int CPM    = 10;
    localparam int IR_DUR = 200;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_ready;
    logic [2:0] ir_cmd;
    logic       ir_valid;
    logic       estop;
    logic [2:0] motor_cmd;
    logic [7:0] motor_speed;
    logic       busy;
    logic       frame_err;
    logic [7:0] err_count;
    logic [7:0] last_cmd;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    robot_cmd_sequencer #(
        .CLKS_PER_MS (CPM),
        .TIMEOUT_MS  (20),
        .IR_SPEED    (8'd128),
        .IR_DUR_MS   (IR_DUR)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_byte     (rx_byte),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .ir_cmd      (ir_cmd),
        .ir_valid    (ir_valid),
        .estop       (estop),
        .motor_cmd   (motor_cmd),
        .motor_speed (motor_speed),
        .busy        (busy),
        .frame_err   (frame_err),
        .err_count   (err_count),
        .last_cmd    (last_cmd)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 3000 && !rx_ready; i++) begin
            @(posedge clk);
            #1;
        end
        if (!rx_ready) check("handshake_wait", 32'(rx_ready), 32'd1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] s, input logic [7:0] d,
                              input logic [7:0] k, input int gap);
        logic [7:0] bytes [5];
        bytes = '{8'hA5, c, s, d, k};
        for (int b = 0; b < 5; b++) begin
            send_byte(bytes[b]);
            if (b < 4) repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    task automatic ir_pulse(input logic [2:0] c);
        ir_cmd   = c;
        ir_valid = 1'b1;
        @(posedge clk);
        #1;
        ir_valid = 1'b0;
    endtask

    // Called at the first sample where busy is seen; returns the number of busy cycles.
    task automatic run_len(output int n);
        n = 0;
        while (busy === 1'b1 && n < 30000) begin
            n++;
            @(negedge clk);
        end
    endtask

    function automatic int within1(input int n, input int exp);
        return (n >= exp && n <= exp + 1) ? exp : n;
    endfunction

    initial begin
        #600_000;
        $display("FAIL watchdog expired vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    initial begin
        int         n, pulses, gap, m_err;
        logic [7:0] c, s, d, k, m_last;
        logic       good;

        rst_n = 1'b0; rx_byte = '0; rx_valid = 1'b0;
        ir_cmd = '0; ir_valid = 1'b0; estop = 1'b0;
        repeat (3) samp();
        check("rst_busy_in_reset", 32'(busy), 32'd0);
        check("rst_cmd_in_reset", 32'(motor_cmd), 32'd0);
        rst_n = 1'b1;
        repeat (2) samp();
        check("rst_rx_ready", 32'(rx_ready), 32'd1);
        check("rst_motor_cmd", 32'(motor_cmd), 32'd0);
        check("rst_motor_speed", 32'(motor_speed), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_last_cmd", 32'(last_cmd), 32'd0);

        // FWD 0x80 for 50 ms
        send_frame(8'h01, 8'h80, 8'h05, 8'h84, 0);
        samp();
        check("fwd_slot_full", 32'(rx_ready), 32'd0);
        check("fwd_not_yet_busy", 32'(busy), 32'd0);
        samp();
        check("fwd_busy", 32'(busy), 32'd1);
        check("fwd_cmd", 32'(motor_cmd), 32'd1);
        check("fwd_speed", 32'(motor_speed), 32'h80);
        run_len(n);
        check("fwd_run_len", 32'(within1(n, 50 * CPM)), 32'(50 * CPM));
        check("fwd_end_cmd", 32'(motor_cmd), 32'd0);
        check("fwd_end_speed", 32'(motor_speed), 32'd0);
        check("fwd_last_cmd", 32'(last_cmd), 32'h01);

        // REV untimed, replaced by a STOP frame after 30 ms
        send_frame(8'h02, 8'h40, 8'h00, 8'h42, 0);
        samp(); samp();
        check("rev_cmd", 32'(motor_cmd), 32'd2);
        check("rev_speed", 32'(motor_speed), 32'h40);
        repeat (30 * CPM) samp();
        check("rev_still_busy", 32'(busy), 32'd1);
        send_frame(8'h00, 8'h00, 8'h00, 8'h00, 0);
        samp(); samp();
        check("rev_stop_busy", 32'(busy), 32'd0);
        check("rev_stop_cmd", 32'(motor_cmd), 32'd0);
        check("rev_stop_last", 32'(last_cmd), 32'h00);

        // bad checksum
        send_frame(8'h01, 8'h10, 8'h03, 8'h13, 0);
        samp();
        check("badchk_pulse", 32'(frame_err), 32'd1);
        check("badchk_count", 32'(err_count), 32'd1);
        samp();
        check("badchk_pulse_end", 32'(frame_err), 32'd0);
        check("badchk_busy", 32'(busy), 32'd0);
        check("badchk_last", 32'(last_cmd), 32'h00);

        // inter-byte timeout, then a good frame
        send_byte(8'hA5); send_byte(8'h01);
        pulses = 0;
        for (int i = 0; i < 25 * CPM; i++) begin
            samp();
            if (frame_err) pulses++;
        end
        check("timeout_pulses", 32'(pulses), 32'd1);
        check("timeout_count", 32'(err_count), 32'd2);
        send_frame(8'h03, 8'h20, 8'h02, 8'h21, 0);
        samp(); samp();
        check("post_timeout_cmd", 32'(motor_cmd), 32'd3);
        check("post_timeout_speed", 32'(motor_speed), 32'h20);
        run_len(n);
        check("post_timeout_len", 32'(within1(n, 20 * CPM)), 32'(20 * CPM));

        // 15 ms gap stays inside the timeout
        send_byte(8'hA5); send_byte(8'h04);
        repeat (15 * CPM) begin @(posedge clk); #1; end
        send_byte(8'h30); send_byte(8'h01); send_byte(8'h35);
        samp();
        check("short_gap_no_err", 32'(frame_err), 32'd0);
        samp();
        check("short_gap_cmd", 32'(motor_cmd), 32'd4);
        check("short_gap_count", 32'(err_count), 32'd2);
        run_len(n);
        check("short_gap_len", 32'(within1(n, 10 * CPM)), 32'(10 * CPM));

        // CMD out of range
        send_frame(8'h05, 8'h00, 8'h00, 8'h05, 0);
        samp();
        check("badcmd_pulse", 32'(frame_err), 32'd1);
        check("badcmd_count", 32'(err_count), 32'd3);
        samp();
        check("badcmd_busy", 32'(busy), 32'd0);

        // IR LEFT on the same edge as a completing FWD frame
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h80); send_byte(8'h05);
        rx_byte = 8'h84; rx_valid = 1'b1; ir_cmd = 3'd3; ir_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0; ir_valid = 1'b0;
        samp();
        check("arb_ir_cmd", 32'(motor_cmd), 32'd3);
        check("arb_ir_speed", 32'(motor_speed), 32'd128);
        check("arb_rx_blocked", 32'(rx_ready), 32'd0);
        check("arb_last", 32'(last_cmd), 32'h01);
        run_len(n);
        check("arb_ir_len", 32'(within1(n, IR_DUR * CPM)), 32'(IR_DUR * CPM));
        check("arb_gap_cmd", 32'(motor_cmd), 32'd0);
        check("arb_gap_rx_blocked", 32'(rx_ready), 32'd0);
        samp();
        check("arb_frame_cmd", 32'(motor_cmd), 32'd1);
        check("arb_frame_speed", 32'(motor_speed), 32'h80);
        check("arb_rx_free", 32'(rx_ready), 32'd1);

        // timed FWD running: IR dropped, frame pends, then estop
        ir_pulse(3'd3);
        samp();
        check("timed_ir_dropped", 32'(motor_cmd), 32'd1);
        send_frame(8'h02, 8'h40, 8'h00, 8'h42, 0);
        samp();
        check("pend_rx_blocked", 32'(rx_ready), 32'd0);
        check("pend_cmd_kept", 32'(motor_cmd), 32'd1);
        estop = 1'b1;
        @(posedge clk);
        #1;
        samp();
        check("estop_cmd", 32'(motor_cmd), 32'd0);
        check("estop_speed", 32'(motor_speed), 32'd0);
        check("estop_busy", 32'(busy), 32'd0);
        check("estop_slot_flushed", 32'(rx_ready), 32'd1);
        ir_pulse(3'd1);
        samp();
        check("estop_ir_ignored", 32'(motor_cmd), 32'd0);
        send_frame(8'h04, 8'h11, 8'h00, 8'h15, 0);
        samp(); samp();
        check("estop_frame_discarded", 32'(busy), 32'd0);
        check("estop_frame_last", 32'(last_cmd), 32'h04);
        check("estop_frame_rx", 32'(rx_ready), 32'd1);
        estop = 1'b0;
        repeat (5) samp();
        check("release_cmd", 32'(motor_cmd), 32'd0);
        check("release_busy", 32'(busy), 32'd0);

        // IR from idle, then IR STOP
        ir_pulse(3'd1);
        samp();
        check("ir_fwd_cmd", 32'(motor_cmd), 32'd1);
        check("ir_fwd_speed", 32'(motor_speed), 32'd128);
        ir_pulse(3'd0);
        samp();
        check("ir_stop_busy", 32'(busy), 32'd0);
        check("ir_stop_cmd", 32'(motor_cmd), 32'd0);

        // random frames predicted from the frame rules
        m_err  = 3;
        m_last = 8'h04;
        for (int t = 0; t < 16; t++) begin
            c   = 8'($urandom_range(0, 6));
            s   = 8'($urandom);
            d   = 8'($urandom_range(0, 3));
            k   = c ^ s ^ d;
            if ($urandom_range(0, 3) == 0) k = k ^ 8'h5A;
            gap = $urandom_range(0, 4);
            good = (k == (c ^ s ^ d)) && (c <= 8'd4);
            send_frame(c, s, d, k, gap);
            if (!good) begin
                m_err = (m_err < 255) ? m_err + 1 : 255;
                samp();
                check("rnd_err_pulse", 32'(frame_err), 32'd1);
                check("rnd_err_count", 32'(err_count), 32'(m_err));
                samp();
                check("rnd_err_idle", 32'(busy), 32'd0);
            end else begin
                m_last = c;
                samp(); samp();
                check("rnd_last", 32'(last_cmd), 32'(m_last));
                if (c == 8'd0) begin
                    check("rnd_stop_busy", 32'(busy), 32'd0);
                end else begin
                    check("rnd_cmd", 32'(motor_cmd), 32'(c));
                    check("rnd_speed", 32'(motor_speed), 32'(s));
                    if (d == 8'd0) begin
                        repeat (40) samp();
                        check("rnd_untimed_busy", 32'(busy), 32'd1);
                        send_frame(8'h00, 8'h00, 8'h00, 8'h00, gap);
                        m_last = 8'h00;
                        samp(); samp();
                        check("rnd_untimed_stop", 32'(busy), 32'd0);
                    end else begin
                        run_len(n);
                        check("rnd_run_len", 32'(within1(n, int'(d) * 10 * CPM)), 32'(int'(d) * 10 * CPM));
                        check("rnd_end_cmd", 32'(motor_cmd), 32'd0);
                    end
                end
            end
        end

        // error counter saturation
        for (int i = 0; i < 260; i++) begin
            send_frame(8'h01, 8'h10, 8'h03, 8'h13, 0);
            m_err = (m_err < 255) ? m_err + 1 : 255;
        end
        samp();
        check("err_saturated", 32'(err_count), 32'(m_err));

        // reset mid-frame and mid-run
        ir_pulse(3'd1);
        samp();
        check("pre_reset_busy", 32'(busy), 32'd1);
        send_byte(8'hA5); send_byte(8'h02);
        samp();
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_cmd", 32'(motor_cmd), 32'd0);
        check("arst_err_count", 32'(err_count), 32'd0);
        check("arst_last", 32'(last_cmd), 32'd0);
        samp();
        rst_n = 1'b1;
        samp();
        send_frame(8'h01, 8'h80, 8'h05, 8'h84, 0);
        samp(); samp();
        check("post_reset_cmd", 32'(motor_cmd), 32'd1);
        check("post_reset_speed", 32'(motor_speed), 32'h80);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
